// File: rtl/yapp_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : yapp_pkt_tx
// Description : Packet-level YAPP transmitter. Takes a packet command
//               (address, length) and its payload bytes from a local host,
//               buffers the whole payload, then sends header, payload and
//               parity to the router on in_data/in_data_vld. The router can
//               stall the transfer with in_suspend.
//               Optional feature macro: YAPP_TX_PARITY_ERR_EN adds the
//               corrupt_parity input, which makes the parity of the packet
//               being accepted go out inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module yapp_pkt_tx #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  in_data,
    output logic        in_data_vld,
    input  logic        in_suspend,
    output logic        tx_done,
    output logic        err_len,
`ifdef YAPP_TX_PARITY_ERR_EN
    input  logic        corrupt_parity,
`endif
    output logic [15:0] pkt_count
);

    // Gap length is kept in the legal 1..15 range so it always fits the
    // 4-bit gap counter.
    localparam int         C_GAP_CLAMP = (GAP_CYCLES < 1)  ? 1  :
                                         (GAP_CYCLES > 15) ? 15 : GAP_CYCLES;
    localparam logic [3:0] C_GAP_LAST  = 4'(C_GAP_CLAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HDR  = 3'd2,
        S_PAY  = 3'd3,
        S_PAR  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_addr;
    logic [5:0]  r_len;
    logic [5:0]  r_idx;      // write index while loading, read index while sending
    logic [7:0]  r_parity;   // running XOR of header and every loaded byte
    logic [3:0]  r_gap_cnt;
    logic [7:0]  r_buf [0:63];
`ifdef YAPP_TX_PARITY_ERR_EN
    logic        r_corrupt;
`endif

    logic        w_cmd_fire;
    logic        w_pay_fire;
    logic        w_xfer;
    logic        w_last_idx;
    logic [7:0]  w_par_out;
    logic [7:0]  w_next_byte;

    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_pay_fire  = pay_valid & pay_ready;
    // A byte leaves only when it is valid and the router is not suspending.
    assign w_xfer      = in_data_vld & ~in_suspend;
    assign w_last_idx  = (r_idx == (r_len - 6'd1));
    assign w_next_byte = r_buf[r_idx + 6'd1];

`ifdef YAPP_TX_PARITY_ERR_EN
    assign w_par_out = r_parity ^ {8{r_corrupt}};
`else
    assign w_par_out = r_parity;
`endif

    // Payload storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (w_pay_fire) begin
            r_buf[r_idx] <= pay_data;
        end
    end

    // Packet sequencer: command accept, payload load, serialisation and gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            cmd_ready   <= 1'b1;
            pay_ready   <= 1'b0;
            in_data     <= 8'h00;
            in_data_vld <= 1'b0;
            tx_done     <= 1'b0;
            err_len     <= 1'b0;
            pkt_count   <= 16'h0000;
            r_addr      <= 2'd0;
            r_len       <= 6'd0;
            r_idx       <= 6'd0;
            r_parity    <= 8'h00;
            r_gap_cnt   <= 4'd0;
`ifdef YAPP_TX_PARITY_ERR_EN
            r_corrupt   <= 1'b0;
`endif
        end else begin
            // Both status outputs are single-cycle pulses.
            tx_done <= 1'b0;
            err_len <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr   <= cmd_addr;
                        r_len    <= cmd_len;
                        r_idx    <= 6'd0;
                        // Header is known now, so it seeds the parity.
                        r_parity <= {cmd_len, cmd_addr};
`ifdef YAPP_TX_PARITY_ERR_EN
                        r_corrupt <= corrupt_parity;
`endif
                        if (cmd_len == 6'd0) begin
                            // Empty packet: flag it and stay ready.
                            err_len <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            pay_ready <= 1'b1;
                            r_state   <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_pay_fire) begin
                        r_parity <= r_parity ^ pay_data;
                        if (w_last_idx) begin
                            // Whole payload held: present the header at once.
                            r_idx       <= 6'd0;
                            pay_ready   <= 1'b0;
                            in_data     <= {r_len, r_addr};
                            in_data_vld <= 1'b1;
                            r_state     <= S_HDR;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end

                S_HDR: begin
                    if (w_xfer) begin
                        in_data <= r_buf[r_idx];
                        r_state <= S_PAY;
                    end
                end

                S_PAY: begin
                    if (w_xfer) begin
                        if (w_last_idx) begin
                            in_data <= w_par_out;
                            r_state <= S_PAR;
                        end else begin
                            in_data <= w_next_byte;
                            r_idx   <= r_idx + 6'd1;
                        end
                    end
                end

                S_PAR: begin
                    if (w_xfer) begin
                        in_data     <= 8'h00;
                        in_data_vld <= 1'b0;
                        tx_done     <= 1'b1;
                        pkt_count   <= pkt_count + 16'd1;
                        r_gap_cnt   <= C_GAP_LAST;
                        r_state     <= S_GAP;
                    end
                end

                S_GAP: begin
                    // Idle time between packets; back-pressure is ignored here.
                    if (r_gap_cnt == 4'd0) begin
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end

                default: begin
                    cmd_ready   <= 1'b1;
                    pay_ready   <= 1'b0;
                    in_data     <= 8'h00;
                    in_data_vld <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yapp_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_yapp_pkt_tx
// Description : Self-checking bench for yapp_pkt_tx. Directed packets from
//               the test plan followed by randomized packets, payload
//               starvation and router back-pressure, checked against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yapp_pkt_tx;

    localparam int GAP = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  in_data;
    logic        in_data_vld;
    logic        in_suspend;
    logic        tx_done;
    logic        err_len;
    logic [15:0] pkt_count;
`ifdef YAPP_TX_PARITY_ERR_EN
    logic        corrupt;
`endif

    yapp_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .in_data     (in_data),
        .in_data_vld (in_data_vld),
        .in_suspend  (in_suspend),
        .tx_done     (tx_done),
        .err_len     (err_len),
`ifdef YAPP_TX_PARITY_ERR_EN
        .corrupt_parity (corrupt),
`endif
        .pkt_count   (pkt_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- expected packets (written by the stimulus) ----------
    logic [7:0] exp_mem [64][66];
    int         pkt_wr = 0;
    logic [7:0] pay_buf [64];
    logic       susp_rand = 1'b0;
    int         susp_left = 0;

    // ---------------- reference model state (written by the monitor) ------
    int         cyc = 0;
    int         pkt_rd = 0;
    logic [15:0] mcount = 16'h0;
    logic [7:0] got [$];
    logic       in_pkt = 1'b0;
    logic       loading = 1'b0;
    int         cur_len = 0;
    int         loaded = 0;
    int         nbytes = 0;
    int         stalls = 0;
    int         lp = 0;
    int         gap_k = -1;
    logic       exp_tx = 1'b0;
    logic       exp_err = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Packet-level model, evaluated mid-cycle: checks the DUT state visible in
    // this cycle, then records what the coming edge will transfer.
    always @(negedge clock) begin
        logic tx_now, err_now;
        int   slot;
        if (reset) begin
            got.delete();
            in_pkt  = 1'b0;
            loading = 1'b0;
            gap_k   = -1;
            exp_tx  = 1'b0;
            exp_err = 1'b0;
            mcount  = 16'h0;
            nbytes  = 0;
            stalls  = 0;
            pkt_rd  = pkt_wr;
        end else begin
            tx_now  = exp_tx;
            err_now = exp_err;
            exp_tx  = 1'b0;
            exp_err = 1'b0;
            check("tx_done", tx_done, tx_now);
            check("err_len", err_len, err_now);
            check("pay_ready", pay_ready, loading);
            if (tx_now) begin
                mcount = mcount + 16'd1;
                check("pkt_count", pkt_count, mcount);
                check("pkt_expected", (pkt_wr != pkt_rd), 1);
                slot = pkt_rd % 64;
                for (int i = 0; i < got.size(); i++)
                    check($sformatf("pkt%0d_byte%0d", pkt_rd, i), got[i], exp_mem[slot][i]);
                pkt_rd++;
                gap_k = 0;
            end
            if (gap_k >= 0) begin
                if (gap_k < GAP) begin
                    check("gap_cmd_ready", cmd_ready, 0);
                    check("gap_vld", in_data_vld, 0);
                    gap_k++;
                end else begin
                    check("gap_end_cmd_ready", cmd_ready, 1);
                    gap_k = -1;
                end
            end else if (!in_pkt) begin
                check("idle_cmd_ready", cmd_ready, 1);
                check("idle_vld", in_data_vld, 0);
            end else begin
                check("busy_cmd_ready", cmd_ready, 0);
                if (loading) begin
                    check("load_vld", in_data_vld, 0);
                    if (pay_valid && pay_ready) begin
                        loaded++;
                        if (loaded == cur_len) begin
                            loading = 1'b0;
                            lp = cyc + 1;
                        end
                    end
                end else begin
                    check("pkt_vld", in_data_vld, 1);
                    if (in_data_vld && !in_suspend) begin
                        got.push_back(in_data);
                        nbytes++;
                        if (nbytes == cur_len + 2) begin
                            // Parity edge = last load edge + header + len + parity + stalls.
                            check("parity_edge", cyc + 1, lp + cur_len + 2 + stalls);
                            in_pkt = 1'b0;
                            exp_tx = 1'b1;
                        end
                    end else if (in_data_vld) begin
                        stalls++;
                    end
                end
            end
            if (!in_pkt && gap_k < 0 && !exp_tx && cmd_valid && cmd_ready) begin
                if (cmd_len == 6'd0) begin
                    exp_err = 1'b1;
                end else begin
                    in_pkt  = 1'b1;
                    loading = 1'b1;
                    cur_len = int'(cmd_len);
                    loaded  = 0;
                    nbytes  = 0;
                    stalls  = 0;
                    got.delete();
                end
            end
        end
    end

    // One clock of stimulus; back-pressure is driven only from here.
    task automatic step();
        @(posedge clock);
        #1;
        if (susp_rand) in_suspend = ($urandom_range(0, 3) == 0);
        else           in_suspend = (susp_left > 0);
        if (susp_left > 0) susp_left--;
    endtask

    // starve: 0 = pay_valid held, 1 = toggling, 2 = random.
    // abort_at >= 0: assert reset while payload byte abort_at is on in_data.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input int starve,
                            input logic cp, input int abort_at, input logic hold_first);
        int         i, guard, slot;
        logic       taken;
        logic [7:0] par;
        if (l != 6'd0) begin
            slot = pkt_wr % 64;
            par = {l, a};
            exp_mem[slot][0] = {l, a};
            for (int k = 0; k < int'(l); k++) begin
                exp_mem[slot][k + 1] = pay_buf[k];
                par = par ^ pay_buf[k];
            end
            exp_mem[slot][int'(l) + 1] = cp ? ~par : par;
            pkt_wr++;
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
`ifdef YAPP_TX_PARITY_ERR_EN
        corrupt   = cp;
`endif
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        check("cmd_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        i = 0;
        guard = 0;
        while (i < int'(l) && guard < 2000) begin
            case (starve)
                0:       pay_valid = 1'b1;
                1:       pay_valid = (guard % 2 == 0);
                default: pay_valid = ($urandom_range(0, 2) != 0);
            endcase
            pay_data = pay_buf[i];
            taken = pay_valid && pay_ready;
            step();
            guard++;
            if (taken) i++;
        end
        pay_valid = 1'b0;
        if (hold_first) susp_left = 3;
        guard = 0;
        while (pkt_rd != pkt_wr && guard < 5000) begin
            if (abort_at >= 0 && nbytes == abort_at + 1 && in_data_vld) begin
                check("abort_byte", in_data, pay_buf[abort_at]);
                reset = 1'b1;
                step();
                @(negedge clock);
                check("abort_vld", in_data_vld, 0);
                check("abort_pkt_count", pkt_count, 0);
                check("abort_cmd_ready", cmd_ready, 1);
                step();
                reset = 1'b0;
            end else begin
                step();
                guard++;
            end
        end
        check("pkt_pending", pkt_wr - pkt_rd, 0);
        repeat (GAP + 1) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = 2'd0;
        cmd_len    = 6'd0;
        pay_valid  = 1'b0;
        pay_data   = 8'h00;
        in_suspend = 1'b0;
`ifdef YAPP_TX_PARITY_ERR_EN
        corrupt    = 1'b0;
`endif
        repeat (3) step();
        @(negedge clock);
        check("rst_vld", in_data_vld, 0);
        check("rst_data", in_data, 8'h00);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_err_len", err_len, 0);
        check("rst_pay_ready", pay_ready, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Basic packet.
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 0, 1'b0, -1, 1'b0);
        check("basic_pkt_count", pkt_count, 1);

        // Suspend held for three cycles on the first payload byte.
        pay_buf[0] = 8'hAA; pay_buf[1] = 8'h55;
        send_pkt(2'd0, 6'd2, 0, 1'b0, -1, 1'b1);

        // Maximum length with a starved host.
        for (int k = 0; k < 63; k++) pay_buf[k] = 8'($urandom);
        send_pkt(2'd2, 6'd63, 1, 1'b0, -1, 1'b0);

        // Zero length.
        m0 = mcount;
        send_pkt(2'd3, 6'd0, 0, 1'b0, -1, 1'b0);
        check("zero_pkt_count", pkt_count, m0);

        // Reset in the middle of a len=10 packet, then a len=1 packet.
        for (int k = 0; k < 10; k++) pay_buf[k] = 8'($urandom);
        send_pkt(2'd3, 6'd10, 0, 1'b0, 4, 1'b0);
        pay_buf[0] = 8'($urandom);
        send_pkt(2'd1, 6'd1, 0, 1'b0, -1, 1'b0);
        check("after_rst_pkt_count", pkt_count, 1);

`ifdef YAPP_TX_PARITY_ERR_EN
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 0, 1'b1, -1, 1'b0);
`endif

        // Randomized traffic with random back-pressure and starvation.
        susp_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [5:0] l;
            logic       cp;
            l  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            cp = 1'b0;
`ifdef YAPP_TX_PARITY_ERR_EN
            cp = 1'($urandom);
`endif
            for (int k = 0; k < 64; k++) pay_buf[k] = 8'($urandom);
            send_pkt(2'($urandom), l, $urandom_range(0, 2), cp, -1, 1'b0);
        end
        susp_rand = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
